// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl: issues mult/multu to a serial multiplier, captures the product into HI/LO
// and serves mfhi/mflo/mthi/mtlo with stall, bypass, timeout and cycle counting.
module hilo_mult_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNTW    = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic            SIGNED,
    input  logic [31:0]     SRCA,
    input  logic [31:0]     SRCB,
    input  logic            MFHI,
    input  logic            MFLO,
    input  logic            MTHI,
    input  logic            MTLO,
    input  logic [31:0]     WDATA,
    output logic            MST,
    output logic            MSGN,
    output logic [31:0]     MSRCA,
    output logic [31:0]     MSRCB,
    input  logic [63:0]     PROD,
    input  logic            PRODV,
    output logic [31:0]     HI,
    output logic [31:0]     LO,
    output logic [31:0]     RDATA,
    output logic            STALL,
    output logic            BUSY,
    output logic            ERR,
    output logic [CNTW-1:0] CYCLES
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT} state_t;
    state_t          state, state_nx;
    logic [TW-1:0]   tcnt;
    logic [CNTW-1:0] elapsed, elapsed_inc;
    logic            capture, expire, idle_start;
    always_comb begin
        capture     = state == S_WAIT && PRODV;
        expire      = (state == S_ARM || state == S_WAIT) && tcnt == TW'(TIMEOUT - 1);
        idle_start  = state == S_IDLE && START;
        elapsed_inc = &elapsed ? elapsed : elapsed + CNTW'(1);
        // a product still valid from the previous multiply is ignored until PRODV drops
        state_nx    = state == S_IDLE  ? (START ? S_ISSUE : S_IDLE) :
                      state == S_ISSUE ? S_ARM :
                      state == S_ARM   ? (expire ? S_IDLE : (PRODV ? S_ARM : S_WAIT)) :
                                         ((capture || expire) ? S_IDLE : S_WAIT);
        MST         = state == S_ISSUE;
        BUSY        = state != S_IDLE;
        STALL       = BUSY && (START || MTHI || MTLO || ((MFHI || MFLO) && !capture));
        RDATA       = capture ? (MFHI ? PROD[63:32] : PROD[31:0]) : (MFHI ? HI : LO);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            HI      <= '0;
            LO      <= '0;
            MSRCA   <= '0;
            MSRCB   <= '0;
            MSGN    <= 1'b0;
            ERR     <= 1'b0;
            CYCLES  <= '0;
            tcnt    <= '0;
            elapsed <= '0;
        end else begin
            state <= state_nx;
            if (idle_start) begin
                MSRCA <= SRCA;
                MSRCB <= SRCB;
                MSGN  <= SIGNED;
            end
            if (state == S_IDLE && !START && MTHI) HI <= WDATA;
            if (state == S_IDLE && !START && MTLO) LO <= WDATA;
            if (state == S_ISSUE) begin
                tcnt    <= '0;
                elapsed <= '0;
            end else if (BUSY) begin
                tcnt    <= tcnt + TW'(1);
                elapsed <= elapsed_inc;
            end
            if (capture) begin
                HI     <= PROD[63:32];
                LO     <= PROD[31:0];
                CYCLES <= elapsed_inc;
            end else if (expire) begin
                ERR <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// tb_hilo_mult_ctrl: table vectors, corner sequences and random traffic against an
// arithmetic HI/LO model, with a stub serial multiplier of programmable latency.
module tb_hilo_mult_ctrl;
    logic        CLK = 0, RST = 1, START = 0, SIGNED = 0;
    logic        MFHI = 0, MFLO = 0, MTHI = 0, MTLO = 0, PRODV;
    logic [31:0] SRCA = 0, SRCB = 0, WDATA = 0;
    logic        MST, MSGN, STALL, BUSY, ERR;
    logic [31:0] MSRCA, MSRCB, HI, LO, RDATA;
    logic [63:0] PROD, pend;
    logic [15:0] CYCLES;
    int passed = 0, total = 0, mst_cnt = 0, ph = 0, stale = 0, lat = 3;
    bit stuck = 0;
    logic [31:0] m_hi = 0, m_lo = 0;

    always #5 CLK = ~CLK;

    hilo_mult_ctrl #(.TIMEOUT(64), .CNTW(16)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SIGNED(SIGNED), .SRCA(SRCA), .SRCB(SRCB),
        .MFHI(MFHI), .MFLO(MFLO), .MTHI(MTHI), .MTLO(MTLO), .WDATA(WDATA),
        .MST(MST), .MSGN(MSGN), .MSRCA(MSRCA), .MSRCB(MSRCB), .PROD(PROD), .PRODV(PRODV),
        .HI(HI), .LO(LO), .RDATA(RDATA), .STALL(STALL), .BUSY(BUSY), .ERR(ERR), .CYCLES(CYCLES)
    );

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        logic [63:0] eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Stub multiplier: old PRODV/PROD linger `stale` edges after MST, result appears `lat` edges later
    always @(posedge CLK) begin
        if (RST) begin
            PRODV <= 0; PROD <= 0; ph <= 0;
        end else if (MST) begin
            pend <= ref_prod(MSGN, MSRCA, MSRCB);
            ph <= 1;
            if (stale == 0) PRODV <= 0;
        end else if (ph != 0) begin
            if (ph == stale) PRODV <= 0;
            if (ph == stale + lat) begin
                if (!stuck) begin PRODV <= 1; PROD <= pend; end
                ph <= 0;
            end else ph <= ph + 1;
        end
    end

    always @(posedge CLK) if (MST) mst_cnt <= mst_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge CLK); START = 1; SIGNED = s; SRCA = a; SRCB = b;
        #1;
        while (STALL && n < 200) begin @(negedge CLK); #1; n++; end
        if (STALL) begin total++; $display("FAIL issue_bound: START never accepted"); end
        @(negedge CLK); START = 0;
    endtask

    task automatic wait_idle(output int nb);
        nb = 0;
        while (BUSY && nb < 300) begin nb++; @(negedge CLK); end
        if (BUSY) begin total++; $display("FAIL idle_bound: BUSY stuck after %0d cycles", nb); end
    endtask

    task automatic mult_chk(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el, input int st, input int lt);
        int nb, m0;
        stale = st; lat = lt; m0 = mst_cnt;
        issue(s, a, b);
        wait_idle(nb);
        check({name, "_hi"}, HI, eh);
        check({name, "_lo"}, LO, el);
        check({name, "_cycles"}, CYCLES, st + lt + 1);
        check({name, "_mst"}, mst_cnt - m0, 1);
        check({name, "_busy"}, nb, st + lt + 2);
        m_hi = eh; m_lo = el;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        return ($urandom % 4 == 0) ? c[$urandom % 5] : $urandom;
    endfunction

    typedef struct {logic s; logic [31:0] a, b, hi, lo; int st, lt;} vec_t;
    vec_t v[8];

    initial begin
        int n, nb, m0;
        logic [31:0] a, b, w;
        logic [63:0] p;
        logic s, h, l;
        v[0] = '{1'b0, 32'd7, 32'd6, 32'h0, 32'h2A, 0, 3};
        v[1] = '{1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 2, 4};
        v[2] = '{1'b0, 32'hFFFFFFFD, 32'd5, 32'h4, 32'hFFFFFFF1, 1, 2};
        v[3] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 2, 1};
        v[4] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 0, 1};
        v[5] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1, 5};
        v[6] = '{1'b0, 32'h80000000, 32'd2, 32'h1, 32'h0, 2, 7};
        v[7] = '{1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 0, 2};

        repeat (2) @(negedge CLK);
        RST = 0;
        #1;
        check("rst_hi", HI, 0); check("rst_lo", LO, 0); check("rst_busy", BUSY, 0);
        check("rst_err", ERR, 0); check("rst_cycles", CYCLES, 0); check("rst_mst", MST, 0);
        check("rst_stall", STALL, 0); check("rst_msgn", MSGN, 0); check("rst_msrca", MSRCA, 0);

        for (int i = 0; i < 8; i++)
            mult_chk($sformatf("vec%0d", i), v[i].s, v[i].a, v[i].b, v[i].hi, v[i].lo, v[i].st, v[i].lt);

        // mflo held during a multiply stalls until the capture cycle, which forwards the product
        stale = 0; lat = 4;
        @(negedge CLK); START = 1; SIGNED = 0; SRCA = 32'hFFFFFFFF; SRCB = 32'hFFFFFFFF;
        @(negedge CLK); START = 0; MFLO = 1;
        n = 0; #1;
        while (STALL && n < 50) begin n++; @(negedge CLK); #1; end
        check("byp_stall_cycles", n, 5);
        check("byp_busy", BUSY, 1);
        check("byp_rdata", RDATA, 32'h1);
        @(negedge CLK); MFLO = 0;
        check("byp_hi", HI, 32'hFFFFFFFE);
        check("byp_lo", LO, 32'h1);

        // second START held through the first multiply, with PRODV stale when it issues
        stale = 2; lat = 3; m0 = mst_cnt;
        @(negedge CLK); START = 1; SIGNED = 0; SRCA = 2; SRCB = 3;
        @(negedge CLK); SRCA = 4; SRCB = 5;
        n = 0; #1;
        while (STALL && n < 50) begin n++; @(negedge CLK); #1; end
        check("b2b_stall_cycles", n, 7);
        check("b2b_mid_lo", LO, 6);
        @(negedge CLK); START = 0;
        wait_idle(nb);
        check("b2b_lo", LO, 20); check("b2b_hi", HI, 0); check("b2b_mst", mst_cnt - m0, 2);

        // moves, old-value reads, and START priority over MTHI
        @(negedge CLK); MTHI = 1; WDATA = 32'h12345678; MFHI = 1;
        #1; check("mv_old_rdata", RDATA, 0); check("mv_stall", STALL, 0);
        @(negedge CLK); MTHI = 0; MFHI = 0; MTLO = 1; WDATA = 32'h9ABCDEF0;
        check("mthi_hi", HI, 32'h12345678);
        @(negedge CLK); MTLO = 0;
        check("mtlo_lo", LO, 32'h9ABCDEF0); check("mtlo_hi_kept", HI, 32'h12345678);
        @(negedge CLK); MTHI = 1; MTLO = 1; WDATA = 32'h55AA55AA;
        @(negedge CLK); MTHI = 0; MTLO = 0;
        check("mtboth_hi", HI, 32'h55AA55AA); check("mtboth_lo", LO, 32'h55AA55AA);
        stale = 0; lat = 2;
        @(negedge CLK); START = 1; SIGNED = 0; SRCA = 3; SRCB = 3; MTHI = 1; WDATA = 32'hDEADBEEF;
        #1; check("prio_stall", STALL, 0);
        @(negedge CLK); START = 0; MTHI = 0;
        check("prio_hi_kept", HI, 32'h55AA55AA);
        wait_idle(nb);
        check("prio_hi", HI, 0); check("prio_lo", LO, 9);
        m_hi = 0; m_lo = 9;

        for (int i = 0; i < 40; i++) begin
            case ($urandom % 3)
                0: begin
                    s = 1'($urandom); a = pick(); b = pick(); p = ref_prod(s, a, b);
                    mult_chk("rnd_mul", s, a, b, p[63:32], p[31:0], $urandom_range(0, 2), $urandom_range(1, 6));
                end
                1: begin
                    w = $urandom; h = 1'($urandom); l = 1'($urandom);
                    @(negedge CLK); MTHI = h; MTLO = l; WDATA = w;
                    #1; check("rnd_mt_stall", STALL, 0);
                    @(negedge CLK); MTHI = 0; MTLO = 0;
                    if (h) m_hi = w;
                    if (l) m_lo = w;
                    check("rnd_mt_hi", HI, m_hi); check("rnd_mt_lo", LO, m_lo);
                end
                default: begin
                    n = $urandom % 3;
                    @(negedge CLK); MFHI = (n != 1); MFLO = (n != 0);
                    #1; check("rnd_mf", RDATA, (n != 1) ? m_hi : m_lo);
                    @(negedge CLK); MFHI = 0; MFLO = 0;
                end
            endcase
        end

        // PRODV never returns: abandon after 64 ARM+WAIT cycles
        stuck = 1; stale = 0; lat = 1;
        issue(1'b0, 32'd11, 32'd13);
        wait_idle(nb);
        check("to_err", ERR, 1); check("to_busy_cycles", nb, 65);
        check("to_hi", HI, m_hi); check("to_lo", LO, m_lo);
        stuck = 0;

        stale = 0; lat = 20;
        @(negedge CLK); START = 1; SIGNED = 1; SRCA = 9; SRCB = 9;
        @(negedge CLK); START = 0;
        repeat (5) @(negedge CLK);
        check("rstw_busy_before", BUSY, 1);
        RST = 1;
        @(negedge CLK); RST = 0;
        check("rstw_busy", BUSY, 0); check("rstw_hi", HI, 0); check("rstw_lo", LO, 0);
        check("rstw_err", ERR, 0); check("rstw_cycles", CYCLES, 0); check("rstw_msrca", MSRCA, 0);
        check("rstw_msrcb", MSRCB, 0); check("rstw_msgn", MSGN, 0); check("rstw_stall", STALL, 0);
        repeat (30) @(negedge CLK);
        check("rstw_nocap_hi", HI, 0); check("rstw_nocap_lo", LO, 0); check("rstw_idle", BUSY, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hilo_mult_ctrl.md
Name: hilo_mult_ctrl

Overview:
- Pipeline-side initiator for the serial multiplier. It accepts mult/multu requests from the execute stage and drives the multiplier's start, sign and operand inputs.
- It waits for product-valid, then captures the 64-bit product into architectural HI/LO registers.
- It serves mfhi/mflo/mthi/mtlo and raises STALL while a result or resource is not ready.
- It sits between the execute stage and the multiplier; both blocks share CLK and RST.

Parameters:
- TIMEOUT, 256: maximum cycles spent in ARM+WAIT before the operation is abandoned and ERR is raised.
- CNTW, 16: width of the CYCLES performance counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  execute stage issues mult/multu this cycle.
- SIGNED  in  1  1 = mult, 0 = multu; sampled with START.
- SRCA  in  32  operand A; sampled with START.
- SRCB  in  32  operand B; sampled with START.
- MFHI  in  1  read HI request.
- MFLO  in  1  read LO request.
- MTHI  in  1  write HI request.
- MTLO  in  1  write LO request.
- WDATA  in  32  data for MTHI/MTLO.
- MST  out  1  multiplier start.
- MSGN  out  1  multiplier signed flag.
- MSRCA  out  32  multiplier operand A.
- MSRCB  out  32  multiplier operand B.
- PROD  in  64  multiplier product.
- PRODV  in  1  multiplier product valid; level signal that stays high after completion until the next start.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.
- RDATA  out  32  result of MFHI/MFLO.
- STALL  out  1  hold the execute stage, which keeps its request inputs stable.
- BUSY  out  1  a multiply is outstanding (state is not IDLE).
- ERR  out  1  sticky timeout flag; cleared only by RST.
- CYCLES  out  CNTW  cycles from ISSUE to capture of the last completed multiply; saturates at all-ones.

Behaviour:
- Reset (synchronous):
  - state = IDLE; HI = LO = 0.
  - Operand registers = 0; MSGN = 0; ERR = 0; CYCLES = 0.
  - MST = 0; STALL = 0.
  - RST mid-operation abandons the multiply; no capture occurs.
- States:
  - IDLE: START=1 registers SRCA, SRCB, SIGNED into MSRCA, MSRCB, MSGN and moves to ISSUE. START has priority over MTHI/MTLO in the same cycle; those writes are ignored and STALL is not raised for them.
  - ISSUE: MST=1 for exactly this one cycle. Timeout counter and CYCLES counter clear. Always moves to ARM.
  - ARM: PRODV may still be high from the previous product for up to 2 cycles after MST. Ignore PRODV until it is sampled low, then move to WAIT.
  - WAIT: on PRODV=1 at an edge, HI <= PROD[63:32], LO <= PROD[31:0], CYCLES <= elapsed count, then return to IDLE.
- Timeout:
  - Counter increments each cycle in ARM and WAIT.
  - When it reaches TIMEOUT, ERR <= 1, HI/LO stay unchanged, state returns to IDLE.
- MST is a combinational decode of state ISSUE only. MSRCA, MSRCB and MSGN stay stable from ISSUE until the next START.
- STALL is combinational:
  - START while state is not IDLE → STALL=1.
  - MFHI, MFLO, MTHI or MTLO while state is not IDLE → STALL=1, except MFHI/MFLO in WAIT with PRODV=1.
  - Otherwise STALL=0.
- Read path:
  - RDATA = MFHI ? HI : LO when in IDLE.
  - In the WAIT capture cycle, RDATA bypasses PROD[63:32] or PROD[31:0] (same-cycle forwarding, no stall).
  - MFHI and MFLO together is illegal; MFHI wins.
- Write path:
  - In IDLE, MTHI → HI <= WDATA and MTLO → LO <= WDATA at the next edge. Both may be asserted in the same cycle.
  - An MFHI/MFLO issued in the same cycle as MTHI/MTLO returns the old value.
- Back-to-back: START issued in the capture cycle stalls for one cycle, is accepted in IDLE, then ISSUE follows.
- Width rules: no arithmetic on data. CYCLES counter saturates at all-ones.

Test Plan:
- Unsigned multiply: reset, START SIGNED=0 SRCA=7 SRCB=6 → MST pulses exactly once; BUSY until capture; HI=0x00000000, LO=0x0000002A; CYCLES nonzero.
- Signed multiply: START SIGNED=1 SRCA=0xFFFFFFFD SRCB=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Repeat as multu with the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- Stall and bypass: MFLO held from the cycle after START of 0xFFFFFFFF*0xFFFFFFFF unsigned → STALL=1 until capture; RDATA=0x00000001 in the capture cycle; HI afterwards = 0xFFFFFFFE.
- Stale valid: back-to-back START (2*3 then 4*5) while PRODV is still high from the first → second capture yields LO=20, never 6; MST pulses twice total.
- Move and priority: in IDLE, MTHI WDATA=0x12345678 with MTLO WDATA=0x9ABCDEF0 → HI/LO updated next edge. Then START with MTHI in the same cycle → HI is not written by MTHI.
- Timeout and reset: stub PRODV stuck low with TIMEOUT=64 → ERR=1 after 64 cycles in ARM+WAIT; state returns to IDLE; HI/LO unchanged. Separately, RST asserted mid-WAIT → all outputs return to reset values next edge.
